// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/write-back
// for one instruction at a time, counts retirements and halts on SYSTEM or illegal opcodes.
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       op_code,
   input  logic             branch_taken,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             retire,
   output logic             halted,
   output logic             illegal,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] instret
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   // Instruction classes; C_NONE is the cleared value held until the first decode.
   localparam logic [3:0] C_NONE    = 4'd0;
   localparam logic [3:0] C_LOAD    = 4'd1;
   localparam logic [3:0] C_STORE   = 4'd2;
   localparam logic [3:0] C_OPIMM   = 4'd3;
   localparam logic [3:0] C_OP      = 4'd4;
   localparam logic [3:0] C_BRANCH  = 4'd5;
   localparam logic [3:0] C_JAL     = 4'd6;
   localparam logic [3:0] C_JALR    = 4'd7;
   localparam logic [3:0] C_AUIPC   = 4'd8;
   localparam logic [3:0] C_LUI     = 4'd9;
   localparam logic [3:0] C_SYSTEM  = 4'd10;
   localparam logic [3:0] C_ILLEGAL = 4'd11;

   logic [2:0]       r_state;
   logic [2:0]       w_next;
   logic [3:0]       r_class;
   logic [3:0]       w_class;
   logic             r_illegal;
   logic [CNT_W-1:0] r_instret;

   always_comb begin
      case (op_code)
         7'b0000011: w_class = C_LOAD;
         7'b0100011: w_class = C_STORE;
         7'b0010011: w_class = C_OPIMM;
         7'b0110011: w_class = C_OP;
         7'b1100011: w_class = C_BRANCH;
         7'b1101111: w_class = C_JAL;
         7'b1100111: w_class = C_JALR;
         7'b0010111: w_class = C_AUIPC;
         7'b0110111: w_class = C_LUI;
         7'b1110011: w_class = C_SYSTEM;
         default:    w_class = C_ILLEGAL;
      endcase
   end

   // NOTE: every signal written here gets a default first so no path infers a latch.
   always_comb begin
      w_next   = r_state;
      imem_req = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_src   = 2'd0;
      rf_we    = 1'b0;
      wb_sel   = 2'd0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      retire   = 1'b0;
      halted   = 1'b0;
      case (r_state)
         S_IDLE: w_next = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_we  = 1'b1;
               w_next = S_DECODE;
            end
         end
         S_DECODE: begin
            if (w_class == C_SYSTEM || w_class == C_ILLEGAL) w_next = S_HALT;
            else                                              w_next = S_EXEC;
         end
         S_EXEC: begin
            if (r_class == C_BRANCH) begin
               pc_we  = 1'b1;
               pc_src = {1'b0, branch_taken};
               retire = 1'b1;
               w_next = S_FETCH;
            end else if (r_class == C_LOAD || r_class == C_STORE) begin
               w_next = S_MEM;
            end else begin
               w_next = S_WB;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (r_class == C_STORE);
            if (dmem_ready) begin
               if (r_class == C_STORE) begin
                  pc_we  = 1'b1;
                  retire = 1'b1;
                  w_next = S_FETCH;
               end else begin
                  w_next = S_WB;
               end
            end
         end
         S_WB: begin
            rf_we  = 1'b1;
            pc_we  = 1'b1;
            retire = 1'b1;
            w_next = S_FETCH;
            case (r_class)
               C_LOAD:         wb_sel = 2'd1;
               C_JAL, C_JALR:  wb_sel = 2'd2;
               C_LUI:          wb_sel = 2'd3;
               default:        wb_sel = 2'd0;
            endcase
            case (r_class)
               C_JAL:   pc_src = 2'd1;
               C_JALR:  pc_src = 2'd2;
               default: pc_src = 2'd0;
            endcase
         end
         S_HALT:  halted = 1'b1;
         default: w_next = S_IDLE;
      endcase
   end

   // NOTE: state, class, flag and counter use non-blocking assignments and all
   // clear asynchronously so outputs drop to zero the moment rst rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_class   <= C_NONE;
         r_illegal <= 1'b0;
         r_instret <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_class <= w_class;
            if (w_class == C_ILLEGAL) r_illegal <= 1'b1;
         end
         if (retire) r_instret <= r_instret + CNT_W'(1);
      end
   end

   assign state_o = r_state;
   assign illegal = r_illegal;
   assign instret = r_instret;

endmodule
